// File: rtl/decode_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_pkg
// Description : Shared constants, types and instruction-field helpers for the
//               RV32I decode/issue stage (OP, OP-IMM, LUI subset).
// Revision    : 1.0 - initial release
// ============================================================================
package decode_issue_pkg;

    // Major opcodes handled by the stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct3 encodings
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 encodings
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Decoded instruction class; CLS_ILLEGAL covers unknown opcodes and
    // malformed funct7 fields alike.
    typedef enum logic [1:0] {
        CLS_OP      = 2'd0,
        CLS_OP_IMM  = 2'd1,
        CLS_LUI     = 2'd2,
        CLS_ILLEGAL = 2'd3
    } instr_class_e;

    // Operand/control bundle presented to the ALU
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        alu_imm;
        logic [4:0]  rd;
    } issue_bundle_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] i);
        return i[6:0];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] i);
        return i[11:7];
    endfunction

    function automatic logic [2:0] funct3_of(input logic [31:0] i);
        return i[14:12];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] i);
        return i[19:15];
    endfunction

    // Also the shift amount field for OP-IMM shifts
    function automatic logic [4:0] rs2_of(input logic [31:0] i);
        return i[24:20];
    endfunction

    function automatic logic [6:0] funct7_of(input logic [31:0] i);
        return i[31:25];
    endfunction

    function automatic logic [31:0] imm_i_of(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [31:0] imm_u_of(input logic [31:0] i);
        return {i[31:12], 12'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_if
// Description : Instruction handshake, ALU issue bundle and writeback port of
//               the decode/issue stage. master = instruction/writeback source
//               side, slave = the decode/issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alu_imm;
    logic [4:0]  out_rd;
    logic        illegal;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output in_valid, in_instr, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, x, y, funct3, funct7, alu_imm, out_rd, illegal
    );

    modport slave (
        input  in_valid, in_instr, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, x, y, funct3, funct7, alu_imm, out_rd, illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_issue_regfile.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_regfile
// Description : NREGS x XLEN register file, two combinational read ports, one
//               write port. x0 reads zero; a read of the register being written
//               this cycle returns the write data (write-first).
// Ports       : clk, rst_n          - clock, async active-low reset
//               raddr1/2, rdata1/2  - read ports
//               wen, waddr, wdata   - write port (writes to x0 ignored)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic [AW-1:0]   raddr1,
    input  wire logic [AW-1:0]   raddr2,
    output logic      [XLEN-1:0] rdata1,
    output logic      [XLEN-1:0] rdata2,
    input  wire logic            wen,
    input  wire logic [AW-1:0]   waddr,
    input  wire logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    function automatic logic [XLEN-1:0] f_read(input logic [AW-1:0] a);
        if (a == '0) begin
            return '0;
        end else if (wen && (waddr == a)) begin
            return wdata;
        end else begin
            return r_mem[a];
        end
    endfunction

    always_comb begin
        rdata1 = f_read(raddr1);
        rdata2 = f_read(raddr2);
    end

endmodule
`default_nettype wire

// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue
// Description : RV32I decode and operand-issue stage in front of the ALU.
//               Decodes OP / OP-IMM / LUI, reads operands, tracks in-flight
//               destinations in a scoreboard and stalls on RAW hazards.
// Ports       : clk    - clock, posedge active
//               rst_n  - asynchronous active-low reset
//               bus    - decode_issue_if.slave: in_valid/in_ready/in_instr,
//                        registered bundle out_valid/x/y/funct3/funct7/
//                        alu_imm/out_rd, illegal pulse, wb_en/wb_rd/wb_data
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    decode_issue_if.slave bus
);

    logic [31:0]       w_instr;
    logic [6:0]        w_opcode;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [4:0]        w_rd;
    instr_class_e      w_cls;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_stall;
    logic              w_accept;
    logic              w_issue;
    logic [XLEN-1:0]   w_rdata1;
    logic [XLEN-1:0]   w_rdata2;
    issue_bundle_t     w_next;
    logic [NREGS-1:0]  w_pending_next;

    issue_bundle_t     r_bundle;
    logic              r_out_valid;
    logic              r_illegal;
    logic [NREGS-1:0]  r_pending;

    assign w_instr  = bus.in_instr;
    assign w_opcode = opcode_of(w_instr);
    assign w_f3     = funct3_of(w_instr);
    assign w_f7     = funct7_of(w_instr);
    assign w_rs1    = rs1_of(w_instr);
    assign w_rs2    = rs2_of(w_instr);
    assign w_rd     = rd_of(w_instr);

    // Classify; anything not explicitly legal falls through to CLS_ILLEGAL.
    always_comb begin
        w_cls = CLS_ILLEGAL;
        case (w_opcode)
            OPC_OP: begin
                if ((w_f7 == F7_BASE) ||
                    ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR)))) begin
                    w_cls = CLS_OP;
                end
            end
            OPC_OP_IMM: begin
                case (w_f3)
                    F3_SLL:  if (w_f7 == F7_BASE) w_cls = CLS_OP_IMM;
                    F3_SR:   if ((w_f7 == F7_BASE) || (w_f7 == F7_ALT)) w_cls = CLS_OP_IMM;
                    default: w_cls = CLS_OP_IMM;
                endcase
            end
            OPC_LUI: w_cls = CLS_LUI;
            default: w_cls = CLS_ILLEGAL;
        endcase
    end

    // Illegal words use no sources, so they never wait on the scoreboard.
    // A source being written back this cycle is not a hazard: the regfile
    // forwards wb_data to it.
    assign w_use_rs1 = (w_cls == CLS_OP) || (w_cls == CLS_OP_IMM);
    assign w_use_rs2 = (w_cls == CLS_OP);

    assign w_stall =
        (w_use_rs1 && r_pending[w_rs1] && !(bus.wb_en && (bus.wb_rd == w_rs1))) ||
        (w_use_rs2 && r_pending[w_rs2] && !(bus.wb_en && (bus.wb_rd == w_rs2)));

    assign bus.in_ready = !w_stall;
    assign w_accept     = bus.in_valid && !w_stall;
    assign w_issue      = w_accept && (w_cls != CLS_ILLEGAL);

    decode_issue_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (w_rs1),
        .raddr2 (w_rs2),
        .rdata1 (w_rdata1),
        .rdata2 (w_rdata2),
        .wen    (bus.wb_en),
        .waddr  (bus.wb_rd),
        .wdata  (bus.wb_data)
    );

    // Operand/control bundle for the word currently on in_instr
    always_comb begin
        w_next        = '0;
        w_next.funct3 = w_f3;
        w_next.rd     = w_rd;
        case (w_cls)
            CLS_OP: begin
                w_next.x       = w_rdata1;
                w_next.y       = w_rdata2;
                w_next.funct7  = w_f7;
                w_next.alu_imm = (w_f3 == F3_SR) && w_instr[30];
            end
            CLS_OP_IMM: begin
                w_next.x = w_rdata1;
                if ((w_f3 == F3_SLL) || (w_f3 == F3_SR)) begin
                    // Shifts: only the 5-bit shamt reaches y, funct7 picks SRL/SRA
                    w_next.y      = {27'b0, w_rs2};
                    w_next.funct7 = w_f7;
                end else begin
                    w_next.y = imm_i_of(w_instr);
                end
                w_next.alu_imm = (w_f3 == F3_SR) ? w_instr[30] : 1'b1;
            end
            CLS_LUI: begin
                w_next.y       = imm_u_of(w_instr);
                w_next.funct3  = F3_ADD;
                w_next.alu_imm = 1'b1;
            end
            default: ;
        endcase
    end

    // Issue set is applied after the writeback clear so a same-register
    // set/clear leaves the entry pending for the new producer.
    always_comb begin
        w_pending_next = r_pending;
        if (bus.wb_en) begin
            w_pending_next[bus.wb_rd] = 1'b0;
        end
        if (w_issue && (w_rd != '0)) begin
            w_pending_next[w_rd] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_bundle    <= '0;
            r_pending   <= '0;
        end else begin
            r_out_valid <= w_issue;
            r_illegal   <= w_accept && (w_cls == CLS_ILLEGAL);
            if (w_issue) begin
                r_bundle <= w_next;
            end
            r_pending <= w_pending_next;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.illegal   = r_illegal;
    assign bus.x         = r_bundle.x;
    assign bus.y         = r_bundle.y;
    assign bus.funct3    = r_bundle.funct3;
    assign bus.funct7    = r_bundle.funct7;
    assign bus.alu_imm   = r_bundle.alu_imm;
    assign bus.out_rd    = r_bundle.rd;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue
// Description : Self-checking bench for decode_issue. Expected bundles are
//               queued when an instruction is accepted and compared when the
//               stage presents out_valid or illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue;

    typedef struct packed {
        logic        ill;
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        imm;
        logic [4:0]  rd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];
    exp_t m_exp;

    decode_issue_if bus();

    decode_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic ill, input logic [31:0] x, input logic [31:0] y,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic imm, input logic [4:0] rd);
        exp_t e;
        e.ill = ill; e.x = x; e.y = y; e.f3 = f3; e.f7 = f7; e.imm = imm; e.rd = rd;
        return e;
    endfunction

    // Called just after a posedge. Waits (bounded) for in_ready, records the
    // expectation for the accepting edge, returns just after that edge.
    task automatic issue(input logic [31:0] instr, input exp_t e, input bit must_be_ready);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        @(negedge clk);
        if (must_be_ready) check("ready_now", {31'b0, bus.in_ready}, 32'd1);
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_rd   = rd;
        bus.wb_data = data;
        @(posedge clk);
        #1;
        bus.wb_en = 1'b0;
    endtask

    // Output monitor: every out_valid/illegal cycle consumes one expectation
    always @(negedge clk) begin
        if (rst_n && (bus.out_valid || bus.illegal)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                m_exp = exp_q.pop_front();
                check("illegal_flag", {31'b0, bus.illegal}, {31'b0, m_exp.ill});
                check("out_valid_flag", {31'b0, bus.out_valid}, {31'b0, !m_exp.ill});
                if (!m_exp.ill) begin
                    check("x", bus.x, m_exp.x);
                    check("y", bus.y, m_exp.y);
                    check("funct3", {29'b0, bus.funct3}, {29'b0, m_exp.f3});
                    check("funct7", {25'b0, bus.funct7}, {25'b0, m_exp.f7});
                    check("alu_imm", {31'b0, bus.alu_imm}, {31'b0, m_exp.imm});
                    check("out_rd", {27'b0, bus.out_rd}, {27'b0, m_exp.rd});
                end
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, "_illegal"},   {31'b0, bus.illegal},   32'd0);
        check({tag, "_x"},         bus.x,                  32'd0);
        check({tag, "_y"},         bus.y,                  32'd0);
        check({tag, "_funct3"},    {29'b0, bus.funct3},    32'd0);
        check({tag, "_funct7"},    {25'b0, bus.funct7},    32'd0);
        check({tag, "_alu_imm"},   {31'b0, bus.alu_imm},   32'd0);
        check({tag, "_out_rd"},    {27'b0, bus.out_rd},    32'd0);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'h0;
        bus.wb_en    = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;

        // ADDI x1,x0,5
        issue(32'h00500093, mk(0, 32'd0, 32'd5, 3'b000, 7'd0, 1'b1, 5'd1), 1'b1);

        // ADD x2,x1,x1 stalls on x1 until writeback of x1 (bypassed value)
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00108133;
        repeat (2) begin
            @(negedge clk);
            check("raw_stall", {31'b0, bus.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd1;
        bus.wb_data = 32'd5;
        @(negedge clk);
        check("wb_unstall", {31'b0, bus.in_ready}, 32'd1);
        if (bus.in_ready) exp_q.push_back(mk(0, 32'd5, 32'd5, 3'b000, 7'd0, 1'b0, 5'd2));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;

        wb(5'd1, 32'h80000000);
        wb(5'd2, 32'h00000007);

        // SRAI x3,x1,4
        issue(32'h4040D193, mk(0, 32'h80000000, 32'd4, 3'b101, 7'b0100000, 1'b1, 5'd3), 1'b1);
        // SUB x4,x1,x2
        issue(32'h40208233, mk(0, 32'h80000000, 32'd7, 3'b000, 7'b0100000, 1'b0, 5'd4), 1'b1);
        // LUI x5,0xABCDE
        issue(32'hABCDE2B7, mk(0, 32'd0, 32'hABCDE000, 3'b000, 7'd0, 1'b1, 5'd5), 1'b1);
        // ECALL and MUL x6,x3,x3 (x3 pending): illegal, no stall
        issue(32'h00000073, mk(1, 32'd0, 32'd0, 3'd0, 7'd0, 1'b0, 5'd0), 1'b1);
        issue(32'h02318333, mk(1, 32'd0, 32'd0, 3'd0, 7'd0, 1'b0, 5'd0), 1'b1);
        // ADDI x8,x6,1: x6 must not have been marked pending by the illegal MUL
        issue(32'h00130413, mk(0, 32'd0, 32'd1, 3'b000, 7'd0, 1'b1, 5'd8), 1'b1);
        // ADDI x9,x0,-1: sign extension
        issue(32'hFFF00493, mk(0, 32'd0, 32'hFFFFFFFF, 3'b000, 7'd0, 1'b1, 5'd9), 1'b1);
        // ADDI x0,x0,1 then ADD x10,x0,x0 with no stall
        issue(32'h00100013, mk(0, 32'd0, 32'd1, 3'b000, 7'd0, 1'b1, 5'd0), 1'b1);
        issue(32'h00000533, mk(0, 32'd0, 32'd0, 3'b000, 7'd0, 1'b0, 5'd10), 1'b1);
        // Write to x0 is discarded
        wb(5'd0, 32'hFFFFFFFF);
        issue(32'h000005B3, mk(0, 32'd0, 32'd0, 3'b000, 7'd0, 1'b0, 5'd11), 1'b1);

        // Leave a nonzero bundle, then reset while ADD x12,x3,x3 is stalled
        issue(32'hFFF00493, mk(0, 32'd0, 32'hFFFFFFFF, 3'b000, 7'd0, 1'b1, 5'd9), 1'b1);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00318633;
        @(negedge clk);
        check("stall_x3", {31'b0, bus.in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Scoreboard cleared: the stalled word now issues at once, x3 reads 0
        issue(32'h00318633, mk(0, 32'd0, 32'd0, 3'b000, 7'd0, 1'b0, 5'd12), 1'b1);
        // ADD x13,x1,x1: regfile cleared by reset
        issue(32'h001086B3, mk(0, 32'd0, 32'd0, 3'b000, 7'd0, 1'b0, 5'd13), 1'b1);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
